// File: rtl/baud_pkg.sv
// Shared widths, divisor type and the default-divisor helper for the fractional baud generator.
package baud_pkg;

  localparam int BAUD_DIV_W  = 16;
  localparam int BAUD_FRAC_W = 4;

  typedef struct packed {
    logic [BAUD_DIV_W-1:0]  div_int;
    logic [BAUD_FRAC_W-1:0] div_frac;
  } div_t;

  // Fixed-point divisor in 1/2**BAUD_FRAC_W clk units, rounded to nearest.
  function automatic div_t calc_div(input longint clk_freq, input longint baud_rate,
                                    input longint oversample);
    longint den;
    longint fx;
    div_t   d;
    den        = baud_rate * oversample;
    fx         = (clk_freq * (longint'(1) << BAUD_FRAC_W) + den / 2) / den;
    d.div_int  = BAUD_DIV_W'(fx >> BAUD_FRAC_W);
    d.div_frac = BAUD_FRAC_W'(fx);
    return d;
  endfunction

endpackage

// File: rtl/baud_frac_counter.sv
// Oversample period counter with fractional accumulator; tc_o marks the terminal-count cycle,
// os_tick_o is the registered pulse one cycle later.
module baud_frac_counter #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              restart_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              tc_o,
  output logic              os_tick_o
);

  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              os_tick_q, os_tick_d;
  logic [FRAC_W:0]   sum;
  logic [DIV_W-1:0]  int_eff;
  logic [DIV_W:0]    period;
  logic [DIV_W:0]    period_m1;

  // acc only moves at terminal count, so the period stays fixed while it runs
  always_comb begin
    int_eff   = (div_int_i < DIV_W'(2)) ? DIV_W'(2) : div_int_i;
    sum       = {1'b0, acc_q} + {1'b0, div_frac_i};
    period    = {1'b0, int_eff} + {{DIV_W{1'b0}}, sum[FRAC_W]};
    period_m1 = period - (DIV_W+1)'(1);
    tc_o      = enable_i && !restart_i && (cnt_q == period_m1);

    cnt_d     = cnt_q;
    acc_d     = acc_q;
    os_tick_d = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (tc_o) begin
      cnt_d     = '0;
      acc_d     = sum[FRAC_W-1:0];
      os_tick_d = 1'b1;
    end else if (enable_i) begin
      cnt_d = cnt_q + (DIV_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      os_tick_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      os_tick_q <= os_tick_d;
    end
  end

  assign os_tick_o = os_tick_q;

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-divisor baud tick generator: config shadow/apply handshake, bit phase counter,
// mid-bit and bit ticks around the period counter.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = BAUD_DIV_W,
  parameter int FRAC_W     = BAUD_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              restart_i,
  input  logic              cfg_wr_i,
  input  logic [DIV_W-1:0]  cfg_div_int_i,
  input  logic [FRAC_W-1:0] cfg_div_frac_i,
  output logic              cfg_pending_o,
  output logic              os_tick_o,
  output logic              mid_tick_o,
  output logic              baud_tick_o
);

  localparam div_t              DEFAULT_DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam logic [DIV_W-1:0]  DEF_INT     = DIV_W'(DEFAULT_DIV.div_int);
  localparam logic [FRAC_W-1:0] DEF_FRAC    = FRAC_W'(DEFAULT_DIV.div_frac);
  localparam int                PH_W        = $clog2(OVERSAMPLE);

  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_os
    $error("baud_gen_frac: OVERSAMPLE must be even and >= 4");
  end
  if (DEFAULT_DIV.div_int < 2) begin : g_bad_div
    $error("baud_gen_frac: default divisor integer part below 2");
  end

  logic [DIV_W-1:0]  div_int_q, div_int_d, shd_int_q, shd_int_d, new_int;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d, shd_frac_q, shd_frac_d, new_frac;
  logic              pending_q, pending_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              mid_q, mid_d, baud_q, baud_d;
  logic              tc;
  logic              os_tick;

  baud_frac_counter #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .restart_i  (restart_i),
    .div_int_i  (div_int_q),
    .div_frac_i (div_frac_q),
    .tc_o       (tc),
    .os_tick_o  (os_tick)
  );

  // A fresh write takes priority over an older pending shadow value
  always_comb begin
    new_int    = cfg_wr_i ? cfg_div_int_i  : shd_int_q;
    new_frac   = cfg_wr_i ? cfg_div_frac_i : shd_frac_q;
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    pending_d  = pending_q;
    if ((cfg_wr_i || pending_q) && (tc || !enable_i || restart_i)) begin
      div_int_d  = new_int;
      div_frac_d = new_frac;
      pending_d  = 1'b0;
    end else if (cfg_wr_i) begin
      shd_int_d  = cfg_div_int_i;
      shd_frac_d = cfg_div_frac_i;
      pending_d  = 1'b1;
    end

    phase_d = phase_q;
    if (restart_i) begin
      phase_d = '0;
    end else if (tc) begin
      phase_d = (phase_q == PH_W'(OVERSAMPLE-1)) ? '0 : phase_q + PH_W'(1);
    end
    mid_d  = tc && (phase_q == PH_W'(OVERSAMPLE/2-1));
    baud_d = tc && (phase_q == PH_W'(OVERSAMPLE-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_int_q  <= DEF_INT;
      div_frac_q <= DEF_FRAC;
      shd_int_q  <= DEF_INT;
      shd_frac_q <= DEF_FRAC;
      pending_q  <= 1'b0;
      phase_q    <= '0;
      mid_q      <= 1'b0;
      baud_q     <= 1'b0;
    end else begin
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pending_q  <= pending_d;
      phase_q    <= phase_d;
      mid_q      <= mid_d;
      baud_q     <= baud_d;
    end
  end

  assign cfg_pending_o = pending_q;
  assign os_tick_o     = os_tick;
  assign mid_tick_o    = mid_q;
  assign baud_tick_o   = baud_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: divisor table plus hand-timed config/restart/enable/reset sequences.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, restart, cfg_wr;
  logic [15:0] cfg_div_int;
  logic [3:0]  cfg_div_frac;
  logic        cfg_pending, os_tick, mid_tick, baud_tick;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int di;
    int df;
    int p0;
    int p1;
  } vec_t;
  vec_t vecs[7];

  baud_gen_frac dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable),
    .restart_i      (restart),
    .cfg_wr_i       (cfg_wr),
    .cfg_div_int_i  (cfg_div_int),
    .cfg_div_frac_i (cfg_div_frac),
    .cfg_pending_o  (cfg_pending),
    .os_tick_o      (os_tick),
    .mid_tick_o     (mid_tick),
    .baud_tick_o    (baud_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_os(input int limit, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!os_tick && k < limit);
    if (!os_tick) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_os: no os_tick within %0d clk", limit);
    end
  endtask

  task automatic run_until(input int n_os, input int limit, output int t1, output int t2,
                           output int tm, output int tb, output int tn);
    int k;
    int cnt;
    k = 0; cnt = 0; t1 = -1; t2 = -1; tm = -1; tb = -1; tn = -1;
    while (cnt < n_os && k < limit) begin
      @(negedge clk);
      k++;
      if (os_tick) begin
        cnt++;
        if (cnt == 1) t1 = k;
        if (cnt == 2) t2 = k;
        if (cnt == n_os) tn = k;
      end
      if (mid_tick && tm < 0) tm = k;
      if (baud_tick && tb < 0) tb = k;
    end
  endtask

  // Leaves the bench on a negedge with counter, accumulator and phase at 0 and enable=1.
  task automatic start_div(input int di, input int df);
    @(negedge clk);
    enable = 1'b0; cfg_wr = 1'b1;
    cfg_div_int = 16'(di); cfg_div_frac = 4'(df);
    @(negedge clk);
    cfg_wr = 1'b0; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; enable = 1'b1;
  endtask

  initial begin
    int k, t1, t2, tm, tb, tn, ticks;
    vecs[0] = '{4, 0, 4, 4};
    vecs[1] = '{4, 8, 4, 5};
    vecs[2] = '{2, 0, 2, 2};
    vecs[3] = '{0, 0, 2, 2};
    vecs[4] = '{1, 8, 2, 3};
    vecs[5] = '{3, 15, 3, 4};
    vecs[6] = '{7, 4, 7, 7};

    rst_n = 1'b0; enable = 1'b0; restart = 1'b0; cfg_wr = 1'b0;
    cfg_div_int = '0; cfg_div_frac = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_os_tick", os_tick, 0);
    check("reset_mid_tick", mid_tick, 0);
    check("reset_baud_tick", baud_tick, 0);
    check("reset_pending", cfg_pending, 0);

    // default 325.5 divisor
    enable = 1'b1;
    run_until(16, 6000, t1, t2, tm, tb, tn);
    check("default_first_os", t1, 325);
    check("default_second_os", t2, 651);
    check("default_mid", tm, 2604);
    check("default_baud", tb, 5208);
    check("default_16th_os", tn, 5208);

    foreach (vecs[i]) begin
      start_div(vecs[i].di, vecs[i].df);
      check($sformatf("vec%0d_pending", i), cfg_pending, 0);
      wait_os(40, k);
      check($sformatf("vec%0d_period0", i), k, vecs[i].p0);
      wait_os(40, k);
      check($sformatf("vec%0d_period1", i), k, vecs[i].p1);
    end

    start_div(4, 0);
    run_until(16, 200, t1, t2, tm, tb, tn);
    check("div4_first_os", t1, 4);
    check("div4_mid", tm, 32);
    check("div4_baud", tb, 64);

    start_div(4, 8);
    run_until(32, 400, t1, t2, tm, tb, tn);
    check("div4p5_second_os", t2, 9);
    check("div4p5_mid", tm, 36);
    check("div4p5_baud", tb, 72);
    check("div4p5_32_os", tn, 144);

    // cfg_wr mid-period: old period completes, new one follows
    start_div(4, 0);
    repeat (2) @(negedge clk);
    cfg_wr = 1'b1; cfg_div_int = 16'd6; cfg_div_frac = 4'd0;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("midcfg_pending_set", cfg_pending, 1);
    wait_os(20, k);
    check("midcfg_old_period_end", k, 1);
    check("midcfg_pending_clear", cfg_pending, 0);
    cfg_wr = 1'b1; cfg_div_int = 16'd8;
    @(negedge clk);
    cfg_div_int = 16'd5;
    @(negedge clk);
    cfg_wr = 1'b0;
    @(negedge clk);
    check("dblcfg_pending", cfg_pending, 1);
    wait_os(20, k);
    check("dblcfg_old_period_end", k, 3);
    wait_os(20, k);
    check("dblcfg_second_applied", k, 5);

    // restart in the terminal-count cycle
    start_div(4, 0);
    repeat (3) wait_os(20, k);
    repeat (3) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_tick_suppressed", os_tick, 0);
    wait_os(20, k);
    check("restart_next_os", k, 4);
    ticks = 1;
    while (!mid_tick && ticks < 20) begin
      wait_os(20, k);
      ticks++;
    end
    check("restart_mid_on_8th", ticks, 8);

    // enable low for 10 clk mid-period
    start_div(4, 0);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    ticks = 0;
    repeat (10) begin
      @(negedge clk);
      if (os_tick || mid_tick || baud_tick) ticks++;
    end
    check("disabled_no_ticks", ticks, 0);
    enable = 1'b1;
    wait_os(20, k);
    check("enable_resume_remaining", k, 2);

    // async reset mid-tick and while a config is pending
    start_div(4, 0);
    wait_os(20, k);
    #1 rst_n = 1'b0;
    #1 check("async_rst_os_tick", os_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_div(6, 0);
    repeat (2) @(negedge clk);
    cfg_wr = 1'b1; cfg_div_int = 16'd9;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("prerst_pending", cfg_pending, 1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_pending", cfg_pending, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_until(2, 800, t1, t2, tm, tb, tn);
    check("rst_default_div_first", t1, 325);
    check("rst_default_div_second", t2, 651);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
